// File: rtl/alu_seq_if.sv
// Signal bundle between the core control logic, the multiply/divide sequencer and the shared 8-bit ALU.
// The sequencer takes the slave view; the core/ALU side takes the master view.
interface alu_seq_if;
    logic       start;
    logic       op_sel;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       div_by_zero;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_carry;

    modport slave (
        input  start, op_sel, x, y, alu_out, alu_carry,
        output busy, done, result_hi, result_lo, div_by_zero, alu_a, alu_b, alu_op
    );

    modport master (
        output start, op_sel, x, y, alu_out, alu_carry,
        input  busy, done, result_hi, result_lo, div_by_zero, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle 8x8 unsigned shift-add multiplier and 8/8 restoring divider that
// borrows the shared ALU for its ADD/SUB steps; results hold until the next accept.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    // Handshake: start is a request that is accepted only on an edge where the
    // sequencer is in IDLE; it is never queued. Every accept yields exactly one
    // one-cycle done pulse, after which the results stay valid until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SUB = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       is_div;
    logic       dbz;
    logic [7:0] hi;    // MUL product high byte / DIV partial remainder
    logic [7:0] lo;    // MUL multiplier shifting out / DIV quotient shifting in
    logic [7:0] opnd;  // MUL multiplicand / DIV divisor
    logic [7:0] t;

    assign t = {hi[6:0], lo[7]};

    always_comb begin
        state_nxt  = state;
        bus.alu_op = OP_ADD;
        bus.alu_a  = 8'h00;
        bus.alu_b  = 8'h00;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.op_sel && (bus.y == 8'h00)) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.alu_a = opnd;
                if (is_div) begin
                    bus.alu_op = OP_SUB;
                    bus.alu_b  = t;
                end else begin
                    bus.alu_b  = hi;
                end
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            is_div <= 1'b0;
            dbz    <= 1'b0;
            hi     <= 8'h00;
            lo     <= 8'h00;
            opnd   <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= 3'd0;
                        dbz    <= 1'b0;
                        is_div <= bus.op_sel;
                        if (bus.op_sel) begin
                            opnd <= bus.y;
                            if (bus.y == 8'h00) begin
                                hi  <= bus.x;
                                lo  <= 8'hFF;
                                dbz <= 1'b1;
                            end else begin
                                hi <= 8'h00;
                                lo <= bus.x;
                            end
                        end else begin
                            opnd <= bus.x;
                            hi   <= 8'h00;
                            lo   <= bus.y;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 3'd1;
                    if (is_div) begin
                        // hi[7] means the shifted remainder is 9 bits wide and surely >= divisor
                        if (hi[7] | bus.alu_carry) begin
                            hi <= bus.alu_out;
                            lo <= {lo[6:0], 1'b1};
                        end else begin
                            hi <= t;
                            lo <= {lo[6:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        {hi, lo} <= {bus.alu_carry, bus.alu_out, lo[7:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[7:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.result_hi   = hi;
    assign bus.result_lo   = lo;
    assign bus.div_by_zero = dbz;
    assign dbg_state       = state;
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle multiply/divide sequencer that drives the shared 8-bit ALU. It runs 8×8→16 unsigned shift-add multiplication using the ALU ADD op and 8/8 unsigned restoring division using the ALU SUB op. It sits between the core control logic (start/done handshake) and the ALU, and owns the ALU operand/op lines while it runs.

## Interface
Parameters: none (width fixed at 8 to match the ALU).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- op_sel  in  1  0 = MUL, 1 = DIV
- x  in  8  MUL multiplicand / DIV dividend; sampled on accept
- y  in  8  MUL multiplier / DIV divisor; sampled on accept
- busy  out  1  high in RUN state
- done  out  1  one-cycle pulse in DONE state
- result_hi  out  8  MUL product[15:8] / DIV remainder
- result_lo  out  8  MUL product[7:0] / DIV quotient
- div_by_zero  out  1  set with done when DIV had y == 0; held with results
- alu_a  out  8  ALU operand a
- alu_b  out  8  ALU operand b
- alu_op  out  2  ALU op: 0 = SUB (out = b − a, carry = no-borrow), 1 = ADD (carry = bit 8), 2 = NAND
- alu_out  in  8  ALU result
- alu_carry  in  1  ALU carry

## Operation
- States: IDLE, RUN, DONE. Iteration counter cnt is 3 bits.
- IDLE:
  - start=1 latches x, y, and op_sel; clears cnt and div_by_zero.
  - MUL: hi=0, lo=y, mcand=x.
  - DIV: rem=0, quo=x, dvs=y.
  - Next state is RUN, except DIV with y==0 goes directly to DONE with result_hi=x, result_lo=8'hFF, div_by_zero=1.
- RUN, MUL, per cycle:
  - Drive alu_op=ADD, alu_a=mcand, alu_b=hi.
  - If lo[0]=1: {hi,lo} ← {alu_carry, alu_out, lo[7:1]}.
  - Else: {hi,lo} ← {1'b0, hi, lo[7:1]}.
- RUN, DIV, per cycle:
  - t = {rem[6:0], quo[7]}.
  - Drive alu_op=SUB, alu_a=dvs, alu_b=t.
  - If rem[7] | alu_carry: rem ← alu_out, quo ← {quo[6:0],1}.
  - Else: rem ← t, quo ← {quo[6:0],0}.
  - rem[7] marks a 9-bit partial remainder that always exceeds dvs; alu_out mod 256 is then still correct.
- cnt increments each RUN cycle. When cnt==7, the next state is DONE.
- DONE: done=1 for one cycle; next state IDLE unconditionally.
- result_hi/result_lo drive the working registers directly. They are valid from the DONE cycle and hold until the next accepted start.
- ALU drive outside RUN: alu_op=ADD, alu_a=alu_b=0.
- start outside IDLE is ignored; it is not queued. This includes start during DONE.
- op_sel, x, and y changes after accept have no effect.

## Timing
- Reset: state=IDLE, busy=0, done=0, div_by_zero=0, result_hi=result_lo=0, cnt=0.
- Reset mid-operation aborts the operation. It returns to IDLE on the next edge with no done pulse.
- Normal latency: start accepted at edge t0; RUN for cycles t0+1 … t0+8 with busy=1; DONE at t0+9 (done=1, busy=0); IDLE at t0+10. The earliest next accept is at the edge ending cycle t0+10.
- Divide-by-zero latency: start accepted at t0; DONE at t0+1; busy never asserts.
- ALU path is combinational within one cycle: alu_out and alu_carry are consumed at the same edge that ends the cycle in which alu_a, alu_b, and alu_op are driven.
- busy and done are never high together.

## Test plan
- MUL x=13, y=11 -> done at t0+9; result_hi=8'h00, result_lo=8'h8F; div_by_zero=0.
- MUL x=255, y=255 -> result_hi=8'hFE, result_lo=8'h01 (carry path exercised); MUL x=0, y=200 -> 16'h0000.
- DIV x=200, y=7 -> result_lo=28 (8'h1C), result_hi=4; DIV x=255, y=200 -> quotient 1, remainder 55 (9-bit remainder path); DIV x=255, y=1 -> quotient 8'hFF, remainder 0.
- DIV x=8'h5A, y=0 -> done at t0+1; div_by_zero=1, result_hi=8'h5A, result_lo=8'hFF; busy stays 0.
- start held high continuously with changing x and y -> only the IDLE-cycle operands are used; next accept occurs only after DONE→IDLE; exactly one done per accept.
- rst asserted at t0+4 of a MUL -> next cycle IDLE with all outputs at reset values, no done; a fresh MUL 13×11 then completes correctly.
